// File: rtl/radio_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : radio_sched_pkg                                              |
// | Description : Shared types and defaults for the radio enable scheduler.    |
// |               sched_state_t  - scheduler FSM state encoding                |
// |               DEF_*_CYC      - default warm-up / cool-down durations       |
// |               max_int()      - constant helper for width calculations      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package radio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WARMUP   = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } sched_state_t;

  localparam int DEF_WARMUP_CYC   = 16;
  localparam int DEF_COOLDOWN_CYC = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational round-robin arbiter. The search starts at the  |
// |               index after 'last' and wraps; only asserted requests can win.|
// | Ports       : req     [N-1:0]     in  - request vector                     |
// |               last    [IDX_W-1:0] in  - index of the previous winner       |
// |               gnt     [N-1:0]     out - one-hot grant (zero if no request) |
// |               gnt_idx [IDX_W-1:0] out - binary index of the grant          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic w_hit;

  // Two ordered passes: first the indices above 'last', then the wrap-around
  // part from 0 up to and including 'last'.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_hit && req[i] && (i > int'(last))) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        w_hit   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_hit && req[i] && (i <= int'(last))) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        w_hit   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/radio_enable_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : radio_enable_sched                                           |
// | Description : Grants radio active windows to NUM_REQ requesters by         |
// |               round-robin and sequences IDLE -> WARMUP -> ACTIVE ->        |
// |               COOLDOWN. Isolation cuts a window short into COOLDOWN.       |
// | Ports       : ck                    in  - clock, rising edge               |
// |               arst                  in  - async reset, active high         |
// |               isolate_i             in  - power-domain isolation request   |
// |               req_valid_i           in  - per-requester request, held      |
// |               req_len_i             in  - per-requester window length      |
// |               req_ack_o             out - one-cycle grant pulse            |
// |               done_o                out - one-cycle window-end pulse       |
// |               abort_o               out - window ended by isolation        |
// |               owner_o               out - current / last granted index     |
// |               radio_enable_synced_o out - registered radio enable          |
// |               busy_o                out - state is not IDLE                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module radio_enable_sched
  import radio_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int LEN_W        = 8,
  parameter  int WARMUP_CYC   = DEF_WARMUP_CYC,
  parameter  int COOLDOWN_CYC = DEF_COOLDOWN_CYC,
  localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     ck,
  input  logic                     arst,
  input  logic                     isolate_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  output logic [NUM_REQ-1:0]       req_ack_o,
  output logic                     done_o,
  output logic                     abort_o,
  output logic [IDX_W-1:0]         owner_o,
  output logic                     radio_enable_synced_o,
  output logic                     busy_o
);

  // Counter must hold the largest load value without wrapping.
  localparam int CNT_MAX = max_int(max_int(WARMUP_CYC, COOLDOWN_CYC), 2**LEN_W);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_t       r_state,    w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
  logic [LEN_W-1:0]   r_len,      w_len_nxt;
  logic [IDX_W-1:0]   r_owner,    w_owner_nxt;
  logic [NUM_REQ-1:0] r_ack,      w_ack_nxt;
  logic               r_done,     w_done_nxt;
  logic               r_abort,    w_abort_nxt;
  logic               r_radio_en;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [LEN_W-1:0]   w_gnt_len;
  logic               w_cnt_last;
  logic               w_end;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid_i),
    .last    (r_owner),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_gnt_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_gnt_len = req_len_i[i*LEN_W +: LEN_W];
    end
  end

  assign w_cnt_last = (r_cnt <= CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_owner_nxt = r_owner;
    w_ack_nxt   = '0;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    w_end       = 1'b0;
    // Count down but park at 1 so the counter can never wrap.
    w_cnt_nxt   = w_cnt_last ? r_cnt : r_cnt - CNT_W'(1);

    case (r_state)
      IDLE: begin
        if (!isolate_i && (|req_valid_i)) begin
          w_ack_nxt   = w_gnt;
          w_owner_nxt = w_gnt_idx;
          w_len_nxt   = w_gnt_len;
          if (WARMUP_CYC > 0) w_state_nxt = WARMUP;
          else                w_state_nxt = ACTIVE;
        end
      end
      WARMUP: begin
        if (isolate_i)       w_end       = 1'b1;
        else if (w_cnt_last) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (isolate_i || w_cnt_last) w_end = 1'b1;
      end
      COOLDOWN: begin
        if (w_cnt_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Window termination, normal or isolated; a zero cool-down goes straight
    // back to IDLE with the done pulse landing on that IDLE cycle.
    if (w_end) begin
      if (COOLDOWN_CYC > 0) w_state_nxt = COOLDOWN;
      else                  w_state_nxt = IDLE;
      w_done_nxt  = 1'b1;
      w_abort_nxt = isolate_i;
    end

    // Load the duration of the state being entered.
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        WARMUP:   w_cnt_nxt = CNT_W'(WARMUP_CYC);
        ACTIVE:   w_cnt_nxt = (w_len_nxt == '0) ? CNT_W'(1) : CNT_W'(w_len_nxt);
        COOLDOWN: w_cnt_nxt = CNT_W'(COOLDOWN_CYC);
        default:  w_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_owner    <= IDX_W'(NUM_REQ - 1);
      r_ack      <= '0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_radio_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_owner    <= w_owner_nxt;
      r_ack      <= w_ack_nxt;
      r_done     <= w_done_nxt;
      r_abort    <= w_abort_nxt;
      r_radio_en <= (w_state_nxt == ACTIVE);
    end
  end

  assign req_ack_o             = r_ack;
  assign done_o                = r_done;
  assign abort_o               = r_abort;
  assign owner_o               = r_owner;
  assign radio_enable_synced_o = r_radio_en;
  assign busy_o                = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/radio_enable_sched.md
RADIO_ENABLE_SCHED -- requirements
Module: radio_enable_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the radio.
REQ-002 Parameter LEN_W, default 8: width of each requested active-window length.
REQ-003 Parameter WARMUP_CYC, default 16: cycles spent in WARMUP before the radio is enabled.
REQ-004 Parameter COOLDOWN_CYC, default 8: cycles spent in COOLDOWN after the radio is disabled.
REQ-005 Port ck, input, 1: clock, rising edge.
REQ-006 Port arst, input, 1: reset; asynchronous, active-high.
REQ-007 Port isolate_i, input, 1: power-domain isolation request; forces the radio off.
REQ-008 Port req_valid_i, input, NUM_REQ: per-requester window request; each bit is held high until its ack.
REQ-009 Port req_len_i, input, NUM_REQ*LEN_W: per-requester active-window length; slice i belongs to requester i.
REQ-010 Port req_ack_o, output, NUM_REQ: one-cycle pulse to the requester that has been granted.
REQ-011 Port done_o, output, 1: one-cycle pulse when a granted window ends.
REQ-012 Port abort_o, output, 1: qualifies done_o; high when the window ended because of isolation.
REQ-013 Port owner_o, output, $clog2(NUM_REQ): index of the current or last granted requester.
REQ-014 Port radio_enable_synced_o, output, 1: drives radioEnableSynced of the timing-engine interface.
REQ-015 Port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-016 FSM states: IDLE, WARMUP, ACTIVE, COOLDOWN.
REQ-017 IDLE: when isolate_i is low and any req_valid_i bit is high, grant one requester by round-robin.
- Search starts at the index after the last granted owner.
- Pulse req_ack_o for that requester, latch its req_len_i into len_q, update owner_o, go to WARMUP.
REQ-018 WARMUP: stay exactly WARMUP_CYC cycles, then go to ACTIVE.
REQ-019 ACTIVE: radio_enable_synced_o is high for exactly max(len_q,1) cycles, so a length of 0 gives 1 cycle; then go to COOLDOWN.
REQ-020 Entering COOLDOWN: pulse done_o with abort_o low.
REQ-021 COOLDOWN: stay exactly COOLDOWN_CYC cycles, then go to IDLE.
REQ-022 Back-to-back: a new grant may occur on the first IDLE cycle after COOLDOWN, giving one idle cycle minimum between windows.
REQ-023 radio_enable_synced_o is a registered output: it is high only in ACTIVE and is never combinationally derived from inputs.
REQ-024 isolate_i high in WARMUP or ACTIVE:
- Next cycle, radio_enable_synced_o is low and the FSM is in COOLDOWN.
- done_o and abort_o pulse together in that cycle.
REQ-025 isolate_i high in COOLDOWN: COOLDOWN completes normally; no additional done_o.
REQ-026 isolate_i high in IDLE: no grant is issued; pending requests wait without ack.
REQ-027 A requester dropping req_valid_i before ack loses its turn with no side effect.
REQ-028 A grant never goes to a requester whose bit is low, even if it is next in round-robin order.
REQ-029 The cycle counter is $clog2(max(WARMUP_CYC, COOLDOWN_CYC, 2**LEN_W)+1) bits wide.
- It loads on each state entry and counts down to 1; it must not wrap.
REQ-030 WARMUP_CYC=0 or COOLDOWN_CYC=0: the corresponding state is skipped entirely and lasts zero cycles.

Reset
REQ-031 While arst is high: state=IDLE, radio_enable_synced_o=0, req_ack_o=0, done_o=0, abort_o=0, busy_o=0, owner_o=NUM_REQ-1 (so requester 0 has first priority), counter=0, len_q=0.
REQ-032 arst asserted mid-window drops radio_enable_synced_o immediately, asynchronously, with no done_o pulse.
REQ-033 After arst deasserts, the first grant can occur on the first rising edge.

Structure
REQ-034 Package radio_sched_pkg holds:
- the state enum typedef sched_state_t;
- default constants for WARMUP_CYC and COOLDOWN_CYC.
REQ-035 The round-robin grant logic is a sub-module rr_arbiter (parameter N; inputs req and last; outputs gnt one-hot and gnt_idx) and is instantiated once.
REQ-036 All sequential logic is clocked on posedge ck with asynchronous posedge arst.

Verification
REQ-037 Basic window: req_valid_i[2]=1, len=5 from IDLE.
- ack[2] one cycle later.
- 16 cycles of WARMUP, then radio_enable_synced_o high for 5 cycles, then done_o=1 with abort_o=0.
- busy_o falls 8 cycles later.
REQ-038 Round-robin: all four requests held high with len=1.
- Grant order is 0,1,2,3,0.
- Windows are separated by exactly one IDLE cycle.
REQ-039 Zero length: len=0 gives radio_enable_synced_o high for exactly 1 cycle.
REQ-040 Isolation during ACTIVE: isolate_i rises on the 3rd ACTIVE cycle with len=10.
- radio_enable_synced_o is low next cycle.
- done_o and abort_o pulse together.
- COOLDOWN lasts 8 cycles; no grant while isolate_i stays high.
REQ-041 Reset mid-WARMUP: arst pulses.
- All outputs go to reset values at once; owner_o returns to 3.
- A held req_valid_i[0] is acked on the first edge after release.
REQ-042 Parameter sweep: WARMUP_CYC=0 and COOLDOWN_CYC=0 give ACTIVE on the cycle after the grant, and IDLE on the cycle after ACTIVE ends.
